// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: 4x4 row-scanned keypad with per-scan classification and press/release debounce.
module keypad_matrix_scanner #(
  parameter int SCAN_DIV = 5000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
  state_t state, state_n;
  logic [3:0] col_s1, col_s2, hit, cnt, cnt_n, cnt_inc, cand, cand_n, acc_code, row_code, code;
  logic [15:0] div;
  logic [1:0] row, acc_n, row_n, tot, col_idx;
  logic last, eval, accept, none, single, same;
  assign last = div == 16'(SCAN_DIV - 1);
  assign eval = last && row == 2'd3;
  assign key_row = ~(4'b0001 << row);
  assign hit = ~col_s2;
  // per-row key count saturates at 2: anything beyond one key is MULTI
  assign row_n = hit == 4'd0 ? 2'd0 : (hit & (hit - 4'd1)) == 4'd0 ? 2'd1 : 2'd2;
  assign col_idx = hit[0] ? 2'd0 : hit[1] ? 2'd1 : hit[2] ? 2'd2 : 2'd3;
  assign row_code = {row, col_idx};
  assign tot = acc_n == 2'd0 ? row_n : row_n == 2'd0 ? acc_n : 2'd2;
  assign code = acc_n == 2'd0 ? row_code : acc_code;
  assign none = tot == 2'd0;
  assign single = tot == 2'd1;
  assign same = single && code == cand;
  assign cnt_inc = cnt + 4'd1;
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_s1 <= 4'hF;
      col_s2 <= 4'hF;
      div <= '0;
      row <= '0;
      acc_n <= '0;
      acc_code <= '0;
    end else begin
      col_s1 <= key_col;
      col_s2 <= col_s1;
      div <= last ? '0 : div + 16'd1;
      if (last) begin
        row <= row + 2'd1;
        acc_n <= eval ? 2'd0 : tot;
        acc_code <= eval ? 4'd0 : code;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      cand <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cand <= cand_n;
      key_valid <= accept;
      if (accept) key_code <= cand;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cand_n = cand;
    accept = 1'b0;
    if (eval)
      case (state)
        IDLE:
          if (single) begin
            state_n = DEBOUNCE;
            cand_n = code;
            cnt_n = 4'd1;
          end
        DEBOUNCE:
          if (same) begin
            cnt_n = cnt_inc;
            if (cnt_inc == 4'(DEBOUNCE_SCANS)) begin
              state_n = PRESSED;
              accept = 1'b1;
            end
          end else if (single) begin
            cand_n = code;
            cnt_n = 4'd1;
          end else begin
            state_n = IDLE;
            cnt_n = 4'd0;
          end
        PRESSED:
          if (!same) begin
            state_n = RELEASE;
            cnt_n = none ? 4'd1 : 4'd0;
          end
        RELEASE:
          if (none) begin
            cnt_n = cnt_inc;
            if (cnt_inc == 4'(DEBOUNCE_SCANS)) begin
              state_n = IDLE;
              cnt_n = 4'd0;
            end
          end else if (same) state_n = PRESSED;
          else cnt_n = 4'd0;
        default: state_n = IDLE;
      endcase
  end
  always_comb key_held = state == PRESSED || state == RELEASE;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb_keypad_matrix_scanner: directed and random keypad scenarios against a scan-level debounce model.
module tb_keypad_matrix_scanner;
  localparam int SD = 4, DS = 3;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] key_col, key_row, key_code;
  logic key_valid, key_held;
  logic [15:0] mask = '0;
  int checks = 0, errors = 0;
  bit m_held = 0, m_pulse = 0;
  int m_streak = 0, m_gone = 0, m_cand = 0;
  logic [3:0] m_code = '0;
  always #5 clk = ~clk;
  keypad_matrix_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );
  // a down key pulls its column low only while its row is driven
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_row[r] && mask[r*4+c]) key_col[c] = 1'b0;
  end
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_held = 0; m_pulse = 0; m_streak = 0; m_gone = 0; m_cand = 0; m_code = '0;
  endtask
  // accept after DS consecutive single-key scans of the same key; drop after DS consecutive empty scans
  task automatic model_scan(input logic [15:0] m);
    int n, k;
    n = $countones(m);
    k = 0;
    for (int i = 0; i < 16; i++) if (m[i]) k = i;
    m_pulse = 0;
    if (!m_held) begin
      if (n == 1) begin
        m_streak = (k == m_cand && m_streak > 0) ? m_streak + 1 : 1;
        m_cand = k;
        if (m_streak == DS) begin
          m_held = 1; m_code = 4'(k); m_pulse = 1; m_gone = 0;
        end
      end else m_streak = 0;
    end else if (n == 1 && k == m_cand) m_gone = 0;
    else if (n == 0) begin
      m_gone++;
      if (m_gone == DS) begin
        m_held = 0; m_streak = 0;
      end
    end else m_gone = 0;
  endtask
  task automatic run_scan(input logic [15:0] m);
    logic [3:0] exp_row;
    mask = m;
    for (int n = 1; n <= 16; n++) begin
      @(posedge clk);
      if (n == 16) model_scan(m);
      @(negedge clk);
      exp_row = 4'hF;
      exp_row[(n / SD) % 4] = 1'b0;
      chk("key_row", key_row, exp_row);
      chk("key_valid", {3'b0, key_valid}, {3'b0, n == 16 && m_pulse});
      chk("key_held", {3'b0, key_held}, {3'b0, m_held});
      chk("key_code", key_code, m_code);
    end
  endtask
  task automatic run_scans(input logic [15:0] m, input int cnt);
    for (int i = 0; i < cnt; i++) run_scan(m);
  endtask
  initial begin
    int kind, len;
    logic [15:0] m;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_row", key_row, 4'b1110);
      chk("rst_code", key_code, 4'd0);
      chk("rst_valid", {3'b0, key_valid}, 4'd0);
      chk("rst_held", {3'b0, key_held}, 4'd0);
    end
    rst = 1'b1;
    run_scans(16'h0000, 2);
    run_scans(16'h0200, 10);
    run_scans(16'h0000, 4);
    chk("clean_code", key_code, 4'd9);
    run_scans(16'h0020, 2);
    run_scans(16'h0000, 2);
    run_scans(16'h8001, 8);
    run_scans(16'h8000, 4);
    chk("ghost_code", key_code, 4'd15);
    run_scans(16'h0000, 4);
    run_scans(16'h0040, 3);
    run_scan(16'h0000);
    run_scans(16'h0040, 5);
    chk("glitch_code", key_code, 4'd6);
    chk("glitch_held", {3'b0, key_held}, 4'd1);
    run_scans(16'h0000, 4);
    run_scan(16'h0010);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      chk("mid_valid", {3'b0, key_valid}, 4'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    chk("mid_rst_row", key_row, 4'b1110);
    chk("mid_rst_valid", {3'b0, key_valid}, 4'd0);
    chk("mid_rst_held", {3'b0, key_held}, 4'd0);
    run_scans(16'h0010, 4);
    chk("mid_rst_code", key_code, 4'd4);
    run_scans(16'h0000, 4);
    repeat (60) begin
      kind = int'($urandom_range(0, 3));
      len = int'($urandom_range(1, 6));
      m = kind == 0 ? 16'h0000 : (16'd1 << $urandom_range(0, 15));
      if (kind == 3) m = m | (16'd1 << $urandom_range(0, 15));
      run_scans(m, len);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
